rx_module: RTL and testbench
============================

# rx_module

UART receive block, the receiving counterpart of the Tx module. It oversamples the asynchronous `uart_rx_i` line 16× per bit using the shared baud enable, and detects and validates the start bit. It then samples data, optional parity and stop bits at mid-bit and presents the received character with parity and framing status. It sits beside the Tx module under the UART top level and shares its baud generator and configuration field format.

## Interface

**Parameters**
- `MAX_UART_DATA_W`, default 8: maximum data width; `rx_data_o` width.
- `STOP_CONF_W`, default 2: width of the stop-bit configuration field.
- `DATA_CONF_W`, default 2: width of the data-bit configuration field.
- `SAMPLE_COUNT_W`, default 4: width of the oversample counter (16 samples per bit).
- `TOTAL_CONF_W`, default 5: total configuration width.
- `DATA_COUNTER_W`, default 3: width of the data bit index counter.

**Ports**
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `baud_en_i` input 1: one-`clk_i` pulse at 16× the bit rate; all FSM and counter activity advances only on these ticks.
- `rx_en_i` input 1: enables the receiver.
- `rx_conf_i` input `TOTAL_CONF_W`: configuration `{data[1:0], stop[1:0], parity_en}`.
- `uart_rx_i` input 1: external asynchronous UART line; idle high.
- `rx_data_o` output `MAX_UART_DATA_W`: last received character, LSB-aligned, unused upper bits 0.
- `rx_done_o` output 1: one-`clk_i` pulse per completed frame.
- `rx_busy_o` output 1: high while a frame is being received.
- `rx_parity_err_o` output 1: parity status of the last frame.
- `rx_frame_err_o` output 1: stop-bit status of the last frame.

## Operation

**Synchroniser**
- A 2-FF synchroniser on `uart_rx_i` runs on every `clk_i`. Reset value is 1.
- All logic uses the synchronised value `rx_s`.

**Configuration**
- Number of data bits = 5 + `data`.
- Number of stop bits = `stop` + 1.
- Parity is even over the received data bits, with unused upper bits taken as 0.
- `rx_conf_i` is latched on the tick that enters StartBit and is held for the whole frame.

**FSM** (3-bit; transitions only on `baud_en_i` ticks)
- Reset: go to Idle when `rx_en_i`=1.
- Idle: go to StartBit when `rx_s`=0. On entry, clear the sample, data and stop counters.
- StartBit: at sample 7, if `rx_s`=1 (false start), return to Idle with no done pulse. At sample 15, go to RecvData.
- RecvData: at sample 7, store `rx_s` into `data_r[data_idx]` (LSB first). At sample 15 on the last data bit, go to RecvParity if `parity_en`, else RecvStop.
- RecvParity: at sample 7, `parity_err` = `rx_s` XOR (^`data_r`). At sample 15, go to RecvStop.
- RecvStop: at sample 7 of each stop bit, if `rx_s`=0, set the sticky `frame_err` for this frame. At sample 7 of the last stop bit, go to Done. Ending at mid-stop tolerates a sender that is up to half a bit fast.
- Done: go to Idle if `rx_en_i`, else Reset.
- Any undefined state: go to Reset.

**Counters**
- The sample counter runs 0..15 and wraps in all receive states.
- The data and stop indices advance at sample 15 and clear on StartBit entry.

**Outputs**
- In the first `clk_i` cycle in Done, `rx_done_o`=1, and `rx_data_o`, `rx_parity_err_o` and `rx_frame_err_o` update together.
- These three outputs then hold until the next Done.
- `rx_parity_err_o` is 0 for frames with parity disabled.
- `rx_busy_o` goes high on the tick entering StartBit and low on the tick leaving Done, or on a false-start return to Idle.

**Mid-frame events**
- `rx_en_i` falling mid-frame: the current frame completes and the FSM then goes to Reset.
- `rst_i` mid-frame: all state returns to reset values and no done pulse is issued.

## Timing

- Reset values: `rx_data_o`=0, `rx_done_o`=0, `rx_busy_o`=0, `rx_parity_err_o`=0, `rx_frame_err_o`=0, FSM=Reset, counters=0.
- Start detection latency: 2 `clk_i` (synchroniser) plus up to 1 baud tick.
- Ticks from StartBit entry to Done entry: 16 + 16·N + 16·P + 16·(S−1) + 8, where N = data bits, P = parity enabled (0/1) and S = stop bits. Example: 8N1 gives 152 ticks.
- Done lasts exactly 1 baud tick, so the earliest next start detect is 1 tick after Done entry.
- Back-to-back frames: a start bit immediately following the stop bit is received with no loss.
- Simultaneous `rst_i` and `baud_en_i`: reset wins.

## Test plan

Bench settings: `baud_en_i` pulses every 4 `clk_i`; the bench transmitter sends 16 ticks per bit.

1. Conf 5'b11_00_0 (8N1), send 0xA5 → exactly one `rx_done_o` pulse 152 ticks after StartBit entry, `rx_data_o`=0xA5, both error flags 0, `rx_busy_o` high throughout.
2. Conf 5'b00_01_1 (5 data, even parity, 2 stop), send 0x15 with parity 1 → `rx_data_o`=0x15, `rx_parity_err_o`=0. Repeat with parity 0 → `rx_data_o`=0x15, `rx_parity_err_o`=1.
3. 8N1, send 0x3C with the stop bit driven 0 → `rx_done_o` pulses, `rx_data_o`=0x3C, `rx_frame_err_o`=1. Next good frame 0x81 → `rx_frame_err_o`=0.
4. Drive a low glitch of 4 ticks on an idle line → no `rx_done_o`, FSM back in Idle, `rx_busy_o` returns 0, `rx_data_o` unchanged.
5. Assert `rst_i` for 1 clk during data bit 3 of 0xFF → all outputs 0 and no done pulse. A subsequent 0x5A frame → `rx_data_o`=0x5A.
6. Two back-to-back 8N1 frames 0x01, 0xFE with no idle gap → two done pulses carrying 0x01 then 0xFE. With `rx_en_i`=0 and a frame sent → FSM stays in Reset and no done pulse.

Source files
------------

// File: rtl/rx_module.sv
// UART receiver: 16x oversampled start detection, mid-bit sampling of data,
// optional even parity and 1-4 stop bits, with parity and framing status.
module rx_module #(
   parameter int MAX_UART_DATA_W = 8,
   parameter int STOP_CONF_W     = 2,
   parameter int DATA_CONF_W     = 2,
   parameter int SAMPLE_COUNT_W  = 4,
   parameter int TOTAL_CONF_W    = 5,
   parameter int DATA_COUNTER_W  = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       baud_en_i,
   input  logic                       rx_en_i,
   input  logic [TOTAL_CONF_W-1:0]    rx_conf_i,
   input  logic                       uart_rx_i,
   output logic [MAX_UART_DATA_W-1:0] rx_data_o,
   output logic                       rx_done_o,
   output logic                       rx_busy_o,
   output logic                       rx_parity_err_o,
   output logic                       rx_frame_err_o
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_IDLE   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [SAMPLE_COUNT_W-1:0] SAMPLE_LAST = {SAMPLE_COUNT_W{1'b1}};
   localparam logic [SAMPLE_COUNT_W-1:0] SAMPLE_MID  = SAMPLE_LAST >> 1;

   function automatic logic even_parity(input logic [MAX_UART_DATA_W-1:0] d);
      return ^d;
   endfunction

   state_t                       state_q, state_d;
   logic [1:0]                   sync_q;
   logic                         rx_s;
   logic [TOTAL_CONF_W-1:0]      conf_q, conf_d;
   logic [SAMPLE_COUNT_W-1:0]    sample_q, sample_d;
   logic [DATA_COUNTER_W-1:0]    data_idx_q, data_idx_d;
   logic [STOP_CONF_W-1:0]       stop_idx_q, stop_idx_d;
   logic [MAX_UART_DATA_W-1:0]   data_q, data_d;
   logic                         parity_err_q, parity_err_d;
   logic                         frame_err_q, frame_err_d;
   logic                         busy_q, busy_d;
   logic [MAX_UART_DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                         done_q, done_d;
   logic                         perr_out_q, perr_out_d;
   logic                         ferr_out_q, ferr_out_d;

   logic                         parity_en_s;
   logic [STOP_CONF_W-1:0]       stop_last_s;
   logic [DATA_COUNTER_W-1:0]    data_last_s;

   assign rx_s        = sync_q[1];
   assign parity_en_s = conf_q[0];
   assign stop_last_s = conf_q[STOP_CONF_W:1];
   assign data_last_s = DATA_COUNTER_W'(32'd4)
                        + DATA_COUNTER_W'(conf_q[TOTAL_CONF_W-1 -: DATA_CONF_W]);

   // Two-flop synchroniser for the asynchronous line, idle-high on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], uart_rx_i};
      end
   end

   // Next-state, counters and output updates; everything advances on baud ticks.
   always_comb begin
      state_d      = state_q;
      conf_d       = conf_q;
      sample_d     = sample_q;
      data_idx_d   = data_idx_q;
      stop_idx_d   = stop_idx_q;
      data_d       = data_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      busy_d       = busy_q;
      rx_data_d    = rx_data_q;
      done_d       = 1'b0;
      perr_out_d   = perr_out_q;
      ferr_out_d   = ferr_out_q;
      if (baud_en_i) begin
         case (state_q)
            S_RESET: begin
               if (rx_en_i) state_d = S_IDLE;
               else         state_d = S_RESET;
            end
            S_IDLE: begin
               if (rx_en_i && !rx_s) begin
                  state_d      = S_START;
                  conf_d       = rx_conf_i;
                  sample_d     = '0;
                  data_idx_d   = '0;
                  stop_idx_d   = '0;
                  data_d       = '0;
                  parity_err_d = 1'b0;
                  frame_err_d  = 1'b0;
                  busy_d       = 1'b1;
               end else if (!rx_en_i) begin
                  state_d = S_RESET;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_START: begin
               sample_d = sample_q + SAMPLE_COUNT_W'(1);
               if (sample_q == SAMPLE_MID && rx_s) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else if (sample_q == SAMPLE_LAST) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_START;
               end
            end
            S_DATA: begin
               sample_d = sample_q + SAMPLE_COUNT_W'(1);
               if (sample_q == SAMPLE_MID) begin
                  data_d[data_idx_q] = rx_s;
               end else if (sample_q == SAMPLE_LAST) begin
                  data_idx_d = data_idx_q + DATA_COUNTER_W'(1);
                  if (data_idx_q == data_last_s) begin
                     state_d = parity_en_s ? S_PARITY : S_STOP;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  state_d = S_DATA;
               end
            end
            S_PARITY: begin
               sample_d = sample_q + SAMPLE_COUNT_W'(1);
               if (sample_q == SAMPLE_MID) begin
                  parity_err_d = rx_s ^ even_parity(data_q);
               end else if (sample_q == SAMPLE_LAST) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_PARITY;
               end
            end
            S_STOP: begin
               sample_d = sample_q + SAMPLE_COUNT_W'(1);
               if (sample_q == SAMPLE_MID) begin
                  frame_err_d = frame_err_q | ~rx_s;
                  if (stop_idx_q == stop_last_s) begin
                     state_d    = S_DONE;
                     done_d     = 1'b1;
                     rx_data_d  = data_q;
                     perr_out_d = parity_en_s & parity_err_q;
                     ferr_out_d = frame_err_q | ~rx_s;
                  end else begin
                     state_d = S_STOP;
                  end
               end else if (sample_q == SAMPLE_LAST) begin
                  stop_idx_d = stop_idx_q + STOP_CONF_W'(1);
               end else begin
                  state_d = S_STOP;
               end
            end
            S_DONE: begin
               busy_d  = 1'b0;
               state_d = rx_en_i ? S_IDLE : S_RESET;
            end
            default: begin
               busy_d  = 1'b0;
               state_d = S_RESET;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_RESET;
         conf_q       <= '0;
         sample_q     <= '0;
         data_idx_q   <= '0;
         stop_idx_q   <= '0;
         data_q       <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
         rx_data_q    <= '0;
         done_q       <= 1'b0;
         perr_out_q   <= 1'b0;
         ferr_out_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         conf_q       <= conf_d;
         sample_q     <= sample_d;
         data_idx_q   <= data_idx_d;
         stop_idx_q   <= stop_idx_d;
         data_q       <= data_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
         rx_data_q    <= rx_data_d;
         done_q       <= done_d;
         perr_out_q   <= perr_out_d;
         ferr_out_q   <= ferr_out_d;
      end
   end

   assign rx_data_o       = rx_data_q;
   assign rx_done_o       = done_q;
   assign rx_busy_o       = busy_q;
   assign rx_parity_err_o = perr_out_q;
   assign rx_frame_err_o  = ferr_out_q;

endmodule

// File: tb/tb_rx_module.sv
// Directed bench for rx_module: a bit-level transmitter drives the line at
// 16 baud ticks per bit and each result is checked against hand-computed values.
module tb_rx_module;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       baud_en_i;
   logic       rx_en_i;
   logic [4:0] rx_conf_i;
   logic       uart_rx_i;
   logic [7:0] rx_data_o;
   logic       rx_done_o;
   logic       rx_busy_o;
   logic       rx_parity_err_o;
   logic       rx_frame_err_o;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int tick_cnt = 0;
   int start_tick = 0;
   int done_tick = 0;
   int busy_rises = 0;
   logic busy_prev = 1'b0;
   logic [7:0] done_data [$];

   rx_module dut (
      .clk_i(clk_i), .rst_i(rst_i), .baud_en_i(baud_en_i), .rx_en_i(rx_en_i),
      .rx_conf_i(rx_conf_i), .uart_rx_i(uart_rx_i), .rx_data_o(rx_data_o),
      .rx_done_o(rx_done_o), .rx_busy_o(rx_busy_o),
      .rx_parity_err_o(rx_parity_err_o), .rx_frame_err_o(rx_frame_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      baud_en_i = 1'b0;
      forever begin
         repeat (3) @(negedge clk_i);
         baud_en_i = 1'b1;
         @(negedge clk_i);
         baud_en_i = 1'b0;
      end
   end

   always @(posedge clk_i) begin
      if (baud_en_i) tick_cnt <= tick_cnt + 1;
   end

   always @(negedge clk_i) begin
      busy_prev <= rx_busy_o;
      if (rx_busy_o && !busy_prev) begin
         busy_rises <= busy_rises + 1;
         start_tick <= tick_cnt;
      end
      if (rx_done_o) begin
         done_cnt  <= done_cnt + 1;
         done_tick <= tick_cnt;
         done_data.push_back(rx_data_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk_i);
         while (!baud_en_i) @(posedge clk_i);
      end
      @(negedge clk_i);
   endtask

   task automatic send_bit(input logic b);
      uart_rx_i = b;
      ticks(16);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic par_bit, input int nstop, input logic stop_val);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(d[i]);
      if (par_en) send_bit(par_bit);
      for (int i = 0; i < nstop; i++) send_bit(stop_val);
      uart_rx_i = 1'b1;
   endtask

   int dc0;
   int br0;

   initial begin
      rst_i     = 1'b1;
      rx_en_i   = 1'b0;
      rx_conf_i = 5'b11_00_0;
      uart_rx_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_data", rx_data_o, 8'h00);
      check("rst_done", rx_done_o, 1'b0);
      check("rst_busy", rx_busy_o, 1'b0);
      check("rst_perr", rx_parity_err_o, 1'b0);
      check("rst_ferr", rx_frame_err_o, 1'b0);
      rst_i   = 1'b0;
      rx_en_i = 1'b1;
      ticks(5);

      // 8N1, 0xA5
      dc0 = done_cnt; br0 = busy_rises;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
      ticks(20);
      check("t1_done_cnt", done_cnt - dc0, 1);
      check("t1_data", rx_data_o, 8'hA5);
      check("t1_perr", rx_parity_err_o, 1'b0);
      check("t1_ferr", rx_frame_err_o, 1'b0);
      check("t1_latency", done_tick - start_tick, 152);
      check("t1_busy_rises", busy_rises - br0, 1);
      check("t1_busy_end", rx_busy_o, 1'b0);

      // 5 data, even parity, 2 stop
      rx_conf_i = 5'b00_01_1;
      dc0 = done_cnt;
      send_frame(8'h15, 5, 1'b1, 1'b1, 2, 1'b1);
      ticks(20);
      check("t2a_done_cnt", done_cnt - dc0, 1);
      check("t2a_data", rx_data_o, 8'h15);
      check("t2a_perr", rx_parity_err_o, 1'b0);
      check("t2a_ferr", rx_frame_err_o, 1'b0);
      check("t2a_latency", done_tick - start_tick, 136);
      send_frame(8'h15, 5, 1'b1, 1'b0, 2, 1'b1);
      ticks(20);
      check("t2b_done_cnt", done_cnt - dc0, 2);
      check("t2b_data", rx_data_o, 8'h15);
      check("t2b_perr", rx_parity_err_o, 1'b1);

      // framing error then recovery
      rx_conf_i = 5'b11_00_0;
      dc0 = done_cnt;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
      ticks(20);
      check("t3a_done_cnt", done_cnt - dc0, 1);
      check("t3a_data", rx_data_o, 8'h3C);
      check("t3a_ferr", rx_frame_err_o, 1'b1);
      check("t3a_perr", rx_parity_err_o, 1'b0);
      check("t3a_busy", rx_busy_o, 1'b0);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
      ticks(20);
      check("t3b_done_cnt", done_cnt - dc0, 2);
      check("t3b_data", rx_data_o, 8'h81);
      check("t3b_ferr", rx_frame_err_o, 1'b0);

      // short glitch is a false start
      dc0 = done_cnt; br0 = busy_rises;
      uart_rx_i = 1'b0;
      ticks(4);
      uart_rx_i = 1'b1;
      ticks(20);
      check("t4_done_cnt", done_cnt - dc0, 0);
      check("t4_busy_seen", busy_rises - br0, 1);
      check("t4_busy", rx_busy_o, 1'b0);
      check("t4_data", rx_data_o, 8'h81);

      // reset during data bit 3 of 0xFF
      dc0 = done_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      uart_rx_i = 1'b1;
      ticks(8);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("t5_data", rx_data_o, 8'h00);
      check("t5_busy", rx_busy_o, 1'b0);
      check("t5_perr", rx_parity_err_o, 1'b0);
      check("t5_ferr", rx_frame_err_o, 1'b0);
      ticks(120);
      check("t5_no_done", done_cnt - dc0, 0);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
      ticks(20);
      check("t5_after_cnt", done_cnt - dc0, 1);
      check("t5_after_data", rx_data_o, 8'h5A);

      // back-to-back frames
      dc0 = done_cnt;
      send_frame(8'h01, 8, 1'b0, 1'b0, 1, 1'b1);
      send_frame(8'hFE, 8, 1'b0, 1'b0, 1, 1'b1);
      ticks(20);
      check("t6_done_cnt", done_cnt - dc0, 2);
      check("t6_first", done_data[done_data.size() - 2], 8'h01);
      check("t6_second", done_data[done_data.size() - 1], 8'hFE);
      check("t6_data", rx_data_o, 8'hFE);

      // receiver disabled
      rx_en_i = 1'b0;
      ticks(5);
      dc0 = done_cnt; br0 = busy_rises;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
      ticks(20);
      check("t6_dis_done", done_cnt - dc0, 0);
      check("t6_dis_busy", busy_rises - br0, 0);
      check("t6_dis_data", rx_data_o, 8'hFE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
